// File: rtl/sr165_chain_reader.sv
// Receiver for a daisy-chain of 74x165 PISO shift registers.
// Pulses SH/LD, generates the chain shift clock from CLK, samples QH MSB-first
// and hands the captured word over on a valid/ready interface.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for an accepted start; sr_ld_n=1, sr_clk=0
// LOAD     | sr_ld_n=0 for DIV cycles, chain captures its parallel inputs
// SETTLE   | sr_ld_n=1 for DIV cycles; first bit (QH) sampled on last edge
// SHIFT_HI | sr_clk=1 for DIV cycles, chain advances one bit
// SHIFT_LO | sr_clk=0 for DIV cycles; next bit sampled on last edge
module sr165_chain_reader #(
    parameter int N_CHIPS = 1,
    parameter int DIV     = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 start,
    output logic                 busy,
    output logic                 sr_ld_n,
    output logic                 sr_clk,
    input  logic                 sr_q,
    output logic [8*N_CHIPS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int W  = 8 * N_CHIPS;
    localparam int PW = $clog2(DIV + 1);
    localparam int BW = $clog2(W + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_SETTLE   = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_SHIFT_LO = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [PW-1:0] phase_cnt;
    logic [BW-1:0] bits_left;
    // Holds the W-1 samples taken before the final one; the last sample goes
    // straight into out_data together with these.
    logic [W-2:0]  shreg;

    logic accept;
    logic phase_done;
    logic sample;
    logic last_sample;

    // Handshake-qualified start, phase terminal count and sampling strobes.
    always_comb begin
        accept      = 1'b0;
        phase_done  = (phase_cnt == '0);
        sample      = 1'b0;
        last_sample = 1'b0;
        if (state == ST_IDLE && start && (!out_valid || out_ready)) begin
            accept = 1'b1;
        end
        if (phase_done && (state == ST_SETTLE || state == ST_SHIFT_LO)) begin
            sample = 1'b1;
        end
        if (sample && bits_left == BW'(1)) begin
            last_sample = 1'b1;
        end
    end

    // Next-state decode; every timed state leaves on the phase terminal count.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (phase_done) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (phase_done) state_nxt = last_sample ? ST_IDLE : ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                if (phase_done) state_nxt = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (phase_done) state_nxt = last_sample ? ST_IDLE : ST_SHIFT_HI;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and outputs registered from the next state so the pins never glitch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_IDLE;
            sr_ld_n <= 1'b1;
            sr_clk  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            sr_ld_n <= (state_nxt != ST_LOAD);
            sr_clk  <= (state_nxt == ST_SHIFT_HI);
            busy    <= (state_nxt != ST_IDLE);
        end
    end

    // Phase down-counter: reloaded to DIV-1 on every state change, so each
    // timed state lasts exactly DIV cycles.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            phase_cnt <= '0;
        end else if (state_nxt != state) begin
            phase_cnt <= PW'(DIV - 1);
        end else if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - PW'(1);
        end
    end

    // Remaining-sample down-counter and sample shift register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bits_left <= '0;
            shreg     <= '0;
        end else if (accept) begin
            bits_left <= BW'(W);
        end else if (sample) begin
            bits_left <= bits_left - BW'(1);
            shreg     <= {shreg[W-3:0], sr_q};
        end
    end

    // Output word and valid; a completing read wins over a same-edge handshake.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (last_sample) begin
            out_data  <= {shreg, sr_q};
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sr165_chain_reader.sv
// Directed bench for sr165_chain_reader: several parameterisations, each driven
// by a behavioural 74x165 chain, checked against hand-computed expectations.
`timescale 1ns/1ps
module tb_sr165_chain_reader;

    localparam int NI = 5;
    localparam int NCH [NI] = '{1, 2, 1, 3, 3};
    localparam int DVS [NI] = '{2, 1, 3, 1, 4};

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] start = '0;
    logic [NI-1:0] ordy  = '0;
    logic [NI-1:0] busy;
    logic [NI-1:0] ldn;
    logic [NI-1:0] sck;
    logic [NI-1:0] ov;
    logic [23:0]   par_in [NI];
    logic [23:0]   odat   [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = 8 * NCH[g];
        logic [W-1:0] od;
        logic [W-1:0] chain;
        logic busy_l, ldn_l, sck_l, ov_l, sq;
        logic sck_d     = 1'b0;
        int   ld_low    = 0;
        int   rises     = 0;
        int   viol      = 0;
        int   ncyc      = 0;
        int   last_rise = -1;
        int   min_per   = 1000;

        sr165_chain_reader #(.N_CHIPS(NCH[g]), .DIV(DVS[g])) u_dut (
            .CLK       (clk),
            .nRST      (rst_n),
            .start     (start[g]),
            .busy      (busy_l),
            .sr_ld_n   (ldn_l),
            .sr_clk    (sck_l),
            .sr_q      (sq),
            .out_data  (od),
            .out_valid (ov_l),
            .out_ready (ordy[g])
        );

        assign busy[g] = busy_l;
        assign ldn[g]  = ldn_l;
        assign sck[g]  = sck_l;
        assign ov[g]   = ov_l;
        assign odat[g] = 24'(od);
        assign sq      = chain[W-1];

        // 74x165 chain: parallel load while SH/LD low, shift toward QH on CLK rise
        always @(posedge sck_l or negedge ldn_l) begin
            if (!ldn_l) chain <= par_in[g][W-1:0];
            else        chain <= {chain[W-2:0], 1'b0};
        end

        // Pin monitor: load-low cycles, sr_clk rises, shortest period, SH/LD vs CLK overlap
        always @(negedge clk) begin
            if (!ldn_l) ld_low <= ld_low + 1;
            if (sck_l && !sck_d) begin
                rises <= rises + 1;
                if (last_rise >= 0 && ncyc - last_rise < min_per) min_per <= ncyc - last_rise;
                last_rise <= ncyc;
            end
            assert (!(!ldn_l && sck_l)) else viol <= viol + 1;
            sck_d <= sck_l;
            ncyc  <= ncyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read on instance g; lat = cycles from the accept edge to out_valid.
    task automatic do_read(input int g, input logic [23:0] d, output int lat);
        par_in[g] = d;
        @(negedge clk) start[g] = 1'b1;
        @(negedge clk) start[g] = 1'b0;
        lat = 0;
        while (!ov[g] && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop(input int g, input string tag);
        @(negedge clk) ordy[g] = 1'b1;
        @(negedge clk) ordy[g] = 1'b0;
        check(tag, ov[g], 1'b0);
    endtask

    initial begin
        int lat, r0, l0, g, w;
        logic [23:0] d, mask;

        for (int i = 0; i < NI; i++) par_in[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ld_n", ldn[0], 1'b1);
        check("rst_sr_clk", sck[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_valid", ov[0], 1'b0);
        check("rst_data", odat[0], 24'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: N=1 DIV=2, A5
        r0 = g_dut[0].rises;
        l0 = g_dut[0].ld_low;
        do_read(0, 24'hA5, lat);
        check("t1_latency", lat, 32);
        check("t1_data", odat[0], 24'hA5);
        check("t1_ld_low", g_dut[0].ld_low - l0, 2);
        check("t1_rises", g_dut[0].rises - r0, 7);
        check("t1_busy_end", busy[0], 1'b0);
        pop(0, "t1_pop");

        // 2: N=2 DIV=1, 3C81
        r0 = g_dut[1].rises;
        do_read(1, 24'h3C81, lat);
        check("t2_latency", lat, 32);
        check("t2_data", odat[1], 24'h3C81);
        check("t2_rises", g_dut[1].rises - r0, 15);
        check("t2_min_period", g_dut[1].min_per, 2);
        pop(1, "t2_pop");

        // 3: backpressure, refused start is not remembered
        do_read(0, 24'h0F, lat);
        check("t3_data", odat[0], 24'h0F);
        par_in[0] = 24'hF0;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        check("t3_start_refused", busy[0], 1'b0);
        repeat (5) @(negedge clk);
        check("t3_data_hold", odat[0], 24'h0F);
        check("t3_valid_hold", ov[0], 1'b1);
        @(negedge clk) ordy[0] = 1'b1;
        @(negedge clk);
        check("t3_valid_drop", ov[0], 1'b0);
        ordy[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_no_late_start", busy[0], 1'b0);

        // 4: start held, out_ready=1, back-to-back 11 then 22
        par_in[0] = 24'h11;
        @(negedge clk);
        start[0] = 1'b1;
        ordy[0]  = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!ov[0] && lat < 2000) begin @(negedge clk); lat++; end
        check("t4_lat1", lat, 32);
        check("t4_data1", odat[0], 24'h11);
        check("t4_idle_gap", busy[0], 1'b0);
        par_in[0] = 24'h22;
        @(negedge clk);
        check("t4_restart", busy[0], 1'b1);
        check("t4_consumed", ov[0], 1'b0);
        lat = 0;
        while (!ov[0] && lat < 2000) begin @(negedge clk); lat++; end
        check("t4_lat2", lat, 32);
        check("t4_data2", odat[0], 24'h22);
        start[0] = 1'b0;
        @(negedge clk);
        ordy[0] = 1'b0;
        check("t4_consumed2", ov[0], 1'b0);
        check("t4_idle", busy[0], 1'b0);

        // 5: reset after 3 samples, mid SHIFT_HI
        par_in[0] = 24'hC3;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (13) @(negedge clk);
        check("t5_in_shift", sck[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_sr_clk", sck[0], 1'b0);
        check("t5_ld_n", ldn[0], 1'b1);
        check("t5_busy", busy[0], 1'b0);
        check("t5_valid", ov[0], 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_no_partial", ov[0], 1'b0);
        do_read(0, 24'h5A, lat);
        check("t5_data", odat[0], 24'h5A);
        pop(0, "t5_pop");

        // 6: 200 random reads over DIV {1,3,4} x N_CHIPS {1,3}
        for (int n = 0; n < 200; n++) begin
            g    = 2 + int'($urandom_range(0, 2));
            w    = 8 * NCH[g];
            mask = 24'((32'd1 << w) - 32'd1);
            d    = 24'($urandom) & mask;
            do_read(g, d, lat);
            check("t6_latency", lat, DVS[g] * 2 * w);
            check("t6_data", odat[g], d);
            pop(g, "t6_pop");
        end

        check("ld_clk_overlap0", g_dut[0].viol, 0);
        check("ld_clk_overlap1", g_dut[1].viol, 0);
        check("ld_clk_overlap2", g_dut[2].viol, 0);
        check("ld_clk_overlap3", g_dut[3].viol, 0);
        check("ld_clk_overlap4", g_dut[4].viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
